i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Byte-level I2C target (slave) that answers the team's I2C master block on the same two-wire bus.
- Used as an on-chip responder: an ADT7420-like sensor model for loopback benches, and a target port for a host controller.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address, and ACKs.
- Receives write bytes and serves read bytes through a simple byte handshake to user logic. No clock stretching.

Parameters:
- ADDR, 7'h48, 7-bit target address (ADT7420 default).
- SYNC_STAGES, 2, flip-flop stages on SCL/SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock; must be >= 16x the SCL frequency.
- nreset  input  1  asynchronous active-low reset.
- SCL_hw  input  1  bus SCL; external pull-up.
- SDA_hw  inout  1  bus SDA, open-drain: drives 0 or high-z only.
- rx_byte  output  8  last byte written by the master (data phase only).
- rx_valid  output  1  one-clk pulse when rx_byte updates.
- rx_ack_en  input  1  sampled at ACK drive time for write data: 1 = ACK, 0 = NACK.
- tx_byte  input  8  next byte to return on a read.
- tx_taken  output  1  one-clk pulse when tx_byte is captured into the shifter.
- addr_match  output  1  one-clk pulse on an address match; read_nWrite is valid with it.
- read_nWrite  output  1  R/W bit of the current transfer; held until the next START.
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.
- busy  output  1  high from an addressed START until STOP, or until return to IDLE.

Behaviour:
- Reset (async, nreset=0):
  - SDA released (high-z); state IDLE; bit counter 0; shifter 0.
  - rx_byte=0; all pulses 0; read_nWrite=0; busy=0.
  - Synchroniser flops preset to 1 (idle bus).
  - Reset mid-transfer releases SDA immediately, including during an ACK or a 0 data bit.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops.
  - Edges are derived from the last synced stage versus its previous value.
  - All events below use the synced signals only.
- START: synced SDA falls while synced SCL is high.
  - Accepted from any state, including mid-byte (repeated START).
  - Effects: start_det pulse, state ADDR, bit counter 0, SDA released.
- STOP: synced SDA rises while synced SCL is high.
  - Accepted from any state.
  - Effects: stop_det pulse, state IDLE, SDA released, busy=0.
- If START/STOP coincide with an SCL edge in the same clk, the START/STOP takes priority.
- Bit timing:
  - Sample SDA on the SCL rising edge, MSB first.
  - Change the driven SDA only on the SCL falling edge; sync latency provides hold time.
- States:
  - IDLE: SDA released; waits for START.
  - ADDR: shift 8 bits. After the 8th rising edge, compare bits[7:1] with ADDR.
    - Match: addr_match pulse, latch read_nWrite=bit0, busy=1, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP without driving SDA.
  - ADDR_ACK: drive SDA=0 from the 8th falling edge to the 9th falling edge.
    - At the 9th falling edge, go to RX if write.
    - If read: load tx_byte, pulse tx_taken, drive bit7, go to TX.
  - RX: shift 8 bits; at the 8th rising edge, rx_byte<=shifter and pulse rx_valid.
    - At the 8th falling edge, sample rx_ack_en. 1: drive SDA=0 and go to RX_ACK. 0: release SDA and go to WAIT_STOP.
  - RX_ACK: release SDA at the 9th falling edge; return to RX with counter 0.
  - TX: on each falling edge, drive the next shifter bit (1 = release).
    - After the 8th bit's falling edge, release SDA and go to TX_ACK.
  - TX_ACK: sample master ACK on the 9th rising edge.
    - SDA=0: at the 9th falling edge, load tx_byte, pulse tx_taken, drive bit7, stay in TX.
    - SDA=1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore SCL until STOP (to IDLE) or START (to ADDR).
- General call (address 0x00) is not acknowledged. 10-bit addressing is not supported.
- tx_byte must be stable by the falling edge that ends the ACK phase. User logic refreshes it after each tx_taken.

Decomposition:
- Package i2c_pkg:
  - state encoding localparams (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP);
  - bits-per-byte constant 8;
  - default address 7'h48.
- Sub-module i2c_bus_sync: parameterised synchroniser plus edge/START/STOP detector. Outputs scl_rise, scl_fall, start, stop, sda_s.

Test Plan:
- Master writes addr 0x48+W, then 0x01, 0xA5, with rx_ack_en=1.
  - Required: ACK on all three 9th clocks.
  - rx_valid pulses twice; rx_byte=0x01, then 0xA5.
  - stop_det once; busy falls.
- Master reads addr 0x48+R with tx_byte=0x3C, then 0xC3; master ACKs, then NACKs.
  - Required: bus carries 0x3C, 0xC3; tx_taken pulses twice.
  - SDA released after the NACK; state WAIT_STOP, then IDLE on STOP.
- Address 0x49+W.
  - Required: no ACK (SDA high on the 9th clock), no addr_match, no rx_valid until the next START.
- Write 0x48+W, 0x00, repeated START, 0x48+R.
  - Required: start_det twice; read_nWrite 0, then 1.
  - One rx_valid (0x00); first read byte = tx_byte.
- Write data with rx_ack_en=0.
  - Required: NACK on that byte; subsequent SCL activity ignored until STOP.
- Assert nreset during a TX bit driving 0.
  - Required: SDA high-z the same cycle; all outputs at reset values; the next START is decoded normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C target.
package i2c_pkg;

    // Protocol phases of the target
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam int         BITS_PER_BYTE = 8;
    localparam logic [6:0] DEFAULT_ADDR  = 7'h48;

    // Bit counter landmarks: index of the 8th data bit, the ACK slot, and
    // the point where the ACK slot has started being driven.
    localparam logic [3:0] LAST_BIT_IDX  = 4'(BITS_PER_BYTE - 1);
    localparam logic [3:0] ACK_BIT_IDX   = 4'(BITS_PER_BYTE);
    localparam logic [3:0] ACK_DRIVE_IDX = 4'(BITS_PER_BYTE + 1);

    // Address comparison; the general-call address is never claimed.
    function automatic logic addr_hit(input logic [6:0] rx_addr,
                                      input logic [6:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge and START/STOP condition detection.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_s;
    logic                   w_sda_s;

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    // Synchroniser chains and one-cycle history, preset to an idle (high) bus
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    // SDA may only move while SCL is steadily high for a bus condition
    assign sda_s    = w_sda_s;
    assign scl_rise = w_scl_s & ~r_scl_prev;
    assign scl_fall = ~w_scl_s & r_scl_prev;
    assign start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
    assign stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;

endmodule

// File: rtl/i2c_target.sv
// Byte-level I2C target: address match, write-data receive, read-data
// serve, open-drain SDA. No clock stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       SCL_hw,
    inout  wire        SDA_hw,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_byte,
    output logic       tx_taken,
    output logic       addr_match,
    output logic       read_nWrite,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic w_sda_s;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .nreset   (nreset),
        .scl_in   (SCL_hw),
        .sda_in   (SDA_hw),
        .sda_s    (w_sda_s),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .start    (w_start),
        .stop     (w_stop)
    );

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_sr;
    logic       r_sda_low;
    logic [7:0] r_rx_byte;
    logic       r_rx_valid;
    logic       r_tx_taken;
    logic       r_addr_match;
    logic       r_rnw;
    logic       r_start_det;
    logic       r_stop_det;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] w_sr_nxt;
    logic       w_sda_low_nxt;
    logic [7:0] w_rx_byte_nxt;
    logic       w_rx_valid_nxt;
    logic       w_tx_taken_nxt;
    logic       w_addr_match_nxt;
    logic       w_rnw_nxt;
    logic       w_start_det_nxt;
    logic       w_stop_det_nxt;
    logic       w_busy_nxt;
    logic [7:0] w_shift_in;

    assign w_shift_in = {r_sr[6:0], w_sda_s};

    // Open-drain pad: pull low or float, nothing else
    assign SDA_hw = r_sda_low ? 1'b0 : 1'bz;

    // State register and all datapath flops; reset releases SDA at once
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 4'd0;
            r_sr         <= 8'h00;
            r_sda_low    <= 1'b0;
            r_rx_byte    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_tx_taken   <= 1'b0;
            r_addr_match <= 1'b0;
            r_rnw        <= 1'b0;
            r_start_det  <= 1'b0;
            r_stop_det   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_sr         <= w_sr_nxt;
            r_sda_low    <= w_sda_low_nxt;
            r_rx_byte    <= w_rx_byte_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_tx_taken   <= w_tx_taken_nxt;
            r_addr_match <= w_addr_match_nxt;
            r_rnw        <= w_rnw_nxt;
            r_start_det  <= w_start_det_nxt;
            r_stop_det   <= w_stop_det_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and datapath decode; bus conditions override SCL edges
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_bit_cnt;
        w_sr_nxt         = r_sr;
        w_sda_low_nxt    = r_sda_low;
        w_rx_byte_nxt    = r_rx_byte;
        w_rx_valid_nxt   = 1'b0;
        w_tx_taken_nxt   = 1'b0;
        w_addr_match_nxt = 1'b0;
        w_rnw_nxt        = r_rnw;
        w_start_det_nxt  = 1'b0;
        w_stop_det_nxt   = 1'b0;
        w_busy_nxt       = r_busy;

        if (w_start) begin
            w_start_det_nxt = 1'b1;
            w_state_nxt     = ST_ADDR;
            w_cnt_nxt       = 4'd0;
            w_sda_low_nxt   = 1'b0;
        end else if (w_stop) begin
            w_stop_det_nxt  = 1'b1;
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = 4'd0;
            w_sda_low_nxt   = 1'b0;
            w_busy_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sda_low_nxt = 1'b0;
                end

                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_sr_nxt = w_shift_in;
                        if (r_bit_cnt == LAST_BIT_IDX) begin
                            // r_sr[6:0] holds the 7 address bits, SDA is R/W
                            if (addr_hit(r_sr[6:0], ADDR)) begin
                                w_addr_match_nxt = 1'b1;
                                w_rnw_nxt        = w_sda_s;
                                w_busy_nxt       = 1'b1;
                                w_state_nxt      = ST_ADDR_ACK;
                                w_cnt_nxt        = ACK_BIT_IDX;
                            end else begin
                                w_state_nxt = ST_WAIT_STOP;
                                w_cnt_nxt   = 4'd0;
                            end
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_bit_cnt;
                    end
                end

                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == ACK_BIT_IDX) begin
                            // 8th falling edge: start driving the ACK
                            w_sda_low_nxt = 1'b1;
                            w_cnt_nxt     = ACK_DRIVE_IDX;
                        end else if (r_rnw) begin
                            // 9th falling edge of a read: present bit 7
                            w_sr_nxt       = tx_byte;
                            w_tx_taken_nxt = 1'b1;
                            w_sda_low_nxt  = ~tx_byte[7];
                            w_state_nxt    = ST_TX;
                            w_cnt_nxt      = 4'd0;
                        end else begin
                            w_sda_low_nxt = 1'b0;
                            w_state_nxt   = ST_RX;
                            w_cnt_nxt     = 4'd0;
                        end
                    end else begin
                        w_cnt_nxt = r_bit_cnt;
                    end
                end

                ST_RX: begin
                    if (w_scl_rise && (r_bit_cnt != ACK_BIT_IDX)) begin
                        w_sr_nxt = w_shift_in;
                        if (r_bit_cnt == LAST_BIT_IDX) begin
                            w_rx_byte_nxt  = w_shift_in;
                            w_rx_valid_nxt = 1'b1;
                            w_cnt_nxt      = ACK_BIT_IDX;
                        end else begin
                            w_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == ACK_BIT_IDX)) begin
                        // User logic decides ACK/NACK for this data byte now
                        if (rx_ack_en) begin
                            w_sda_low_nxt = 1'b1;
                            w_state_nxt   = ST_RX_ACK;
                        end else begin
                            w_sda_low_nxt = 1'b0;
                            w_state_nxt   = ST_WAIT_STOP;
                        end
                        w_cnt_nxt = 4'd0;
                    end else begin
                        w_cnt_nxt = r_bit_cnt;
                    end
                end

                ST_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_low_nxt = 1'b0;
                        w_state_nxt   = ST_RX;
                        w_cnt_nxt     = 4'd0;
                    end else begin
                        w_cnt_nxt = r_bit_cnt;
                    end
                end

                ST_TX: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == LAST_BIT_IDX) begin
                            // bit 0 has been clocked: hand SDA to the master
                            w_sda_low_nxt = 1'b0;
                            w_state_nxt   = ST_TX_ACK;
                            w_cnt_nxt     = 4'd0;
                        end else begin
                            w_sda_low_nxt = ~r_sr[6];
                            w_sr_nxt      = {r_sr[6:0], 1'b0};
                            w_cnt_nxt     = r_bit_cnt + 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_bit_cnt;
                    end
                end

                ST_TX_ACK: begin
                    if (w_scl_rise && (r_bit_cnt == 4'd0)) begin
                        if (!w_sda_s) begin
                            w_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt = ST_WAIT_STOP;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                        // master ACKed: next byte, bit 7 on the bus now
                        w_sr_nxt       = tx_byte;
                        w_tx_taken_nxt = 1'b1;
                        w_sda_low_nxt  = ~tx_byte[7];
                        w_state_nxt    = ST_TX;
                        w_cnt_nxt      = 4'd0;
                    end else begin
                        w_cnt_nxt = r_bit_cnt;
                    end
                end

                ST_WAIT_STOP: begin
                    w_sda_low_nxt = 1'b0;
                end

                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = 4'd0;
                    w_sda_low_nxt = 1'b0;
                end
            endcase
        end
    end

    assign rx_byte     = r_rx_byte;
    assign rx_valid    = r_rx_valid;
    assign tx_taken    = r_tx_taken;
    assign addr_match  = r_addr_match;
    assign read_nWrite = r_rnw;
    assign start_det   = r_start_det;
    assign stop_det    = r_stop_det;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a behavioural master drives the bus,
// expected events/bus bits are queued, monitors pop and compare.
module tb_i2c_target;

    localparam int Q = 100;  // quarter SCL period in ns (SCL = clk/40)

    localparam logic [2:0] EV_START = 3'd0;
    localparam logic [2:0] EV_STOP  = 3'd1;
    localparam logic [2:0] EV_ADDR  = 3'd2;
    localparam logic [2:0] EV_RX    = 3'd3;
    localparam logic [2:0] EV_TXT   = 3'd4;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
    } evt_t;

    logic       clk;
    logic       nreset;
    logic       scl_r;
    logic       m_sda_low;
    logic       rx_ack_en;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_taken;
    logic       addr_match;
    logic       read_nWrite;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic       bus_chk;
    logic       sda_val;

    wire sda_bus;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign sda_val = (sda_bus === 1'b0) ? 1'b0 : 1'b1;

    evt_t exp_evt[$];
    logic exp_bus[$];
    int   n_checks = 0;
    int   n_errors = 0;

    i2c_target #(
        .ADDR        (7'h48),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .SCL_hw      (scl_r),
        .SDA_hw      (sda_bus),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ack_en   (rx_ack_en),
        .tx_byte     (tx_byte),
        .tx_taken    (tx_taken),
        .addr_match  (addr_match),
        .read_nWrite (read_nWrite),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_evt(input logic [2:0] k, input logic [7:0] d);
        exp_evt.push_back({k, d});
    endtask

    task automatic check_evt(input logic [2:0] k, input logic [7:0] d);
        evt_t e;
        n_checks++;
        if (exp_evt.size() == 0) begin
            n_errors++;
            $display("FAIL evt_unexpected: got kind %0d data %02h, required no event", k, d);
        end else begin
            e = exp_evt.pop_front();
            if ((e.kind !== k) || (e.data !== d)) begin
                n_errors++;
                $display("FAIL evt: got kind %0d data %02h, required kind %0d data %02h",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // Event monitor: every output pulse must match the head of the queue
    initial begin : evt_mon
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (start_det)  check_evt(EV_START, 8'h00);
                if (addr_match) check_evt(EV_ADDR, {7'b0, read_nWrite});
                if (rx_valid)   check_evt(EV_RX, rx_byte);
                if (tx_taken)   check_evt(EV_TXT, 8'h00);
                if (stop_det)   check_evt(EV_STOP, 8'h00);
            end
        end
    end

    // Bus monitor: samples SDA mid-high on clocks flagged by the master
    initial begin : bus_mon
        logic e;
        forever begin
            @(posedge scl_r);
            if (bus_chk) begin
                #(Q);
                n_checks++;
                if (exp_bus.size() == 0) begin
                    n_errors++;
                    $display("FAIL bus_unexpected: got %0b, required no sample", sda_val);
                end else begin
                    e = exp_bus.pop_front();
                    if (sda_val !== e) begin
                        n_errors++;
                        $display("FAIL bus_bit: got %0b, required %0b", sda_val, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(400us);
        n_errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic m_start;
        m_sda_low = 1'b0; #(Q);
        scl_r     = 1'b1; #(Q);
        m_sda_low = 1'b1; #(Q);
        scl_r     = 1'b0; #(Q);
    endtask

    task automatic m_stop;
        m_sda_low = 1'b1; #(Q);
        scl_r     = 1'b1; #(Q);
        m_sda_low = 1'b0; #(Q);
    endtask

    task automatic m_clock(input logic drive_bit, input logic sample, input logic req);
        m_sda_low = ~drive_bit;
        if (sample) exp_bus.push_back(req);
        bus_chk = sample;
        #(Q);
        scl_r = 1'b1; #(2*Q);
        scl_r = 1'b0;
        bus_chk = 1'b0;
        #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic ack_bit);
        for (int i = 7; i >= 0; i--) m_clock(d[i], 1'b0, 1'b0);
        m_clock(1'b1, 1'b1, ack_bit);
    endtask

    task automatic read_byte(input logic [7:0] d, input logic m_ack, input logic [7:0] next_tx);
        for (int i = 7; i >= 0; i--) m_clock(1'b1, 1'b1, d[i]);
        tx_byte = next_tx;
        m_clock(~m_ack, 1'b0, 1'b0);
    endtask

    initial begin : stim
        nreset    = 1'b0;
        scl_r     = 1'b1;
        m_sda_low = 1'b0;
        bus_chk   = 1'b0;
        rx_ack_en = 1'b1;
        tx_byte   = 8'h3C;
        #(100);
        chk("reset_sda", {15'b0, sda_val}, 16'h0001);
        chk("reset_outs", {rx_byte, rx_valid, tx_taken, addr_match, read_nWrite,
                           start_det, stop_det, busy, 1'b0}, 16'h0000);
        nreset = 1'b1;
        #(4*Q);

        // Write 0x48+W, 0x01, 0xA5, all ACKed
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h00);
        push_evt(EV_RX, 8'h01); push_evt(EV_RX, 8'hA5); push_evt(EV_STOP, 8'h00);
        m_start;
        write_byte(8'h90, 1'b0);
        chk("busy_write", {15'b0, busy}, 16'h0001);
        write_byte(8'h01, 1'b0);
        write_byte(8'hA5, 1'b0);
        m_stop;
        #(Q);
        chk("busy_after_stop", {15'b0, busy}, 16'h0000);

        // Read 0x48+R: 0x3C (master ACK), 0xC3 (master NACK)
        tx_byte = 8'h3C;
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h01);
        push_evt(EV_TXT, 8'h00); push_evt(EV_TXT, 8'h00); push_evt(EV_STOP, 8'h00);
        m_start;
        write_byte(8'h91, 1'b0);
        read_byte(8'h3C, 1'b1, 8'hC3);
        read_byte(8'hC3, 1'b0, 8'hFF);
        chk("sda_after_nack", {15'b0, sda_val}, 16'h0001);
        chk("busy_wait_stop", {15'b0, busy}, 16'h0001);
        m_stop;
        #(Q);
        chk("busy_read_stop", {15'b0, busy}, 16'h0000);

        // Wrong address 0x49+W: no ACK, following byte ignored
        push_evt(EV_START, 8'h00); push_evt(EV_STOP, 8'h00);
        m_start;
        write_byte(8'h92, 1'b1);
        write_byte(8'h77, 1'b1);
        chk("busy_mismatch", {15'b0, busy}, 16'h0000);
        m_stop;

        // Write 0x00, repeated START, read one byte
        tx_byte = 8'h5A;
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h00); push_evt(EV_RX, 8'h00);
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h01); push_evt(EV_TXT, 8'h00);
        push_evt(EV_STOP, 8'h00);
        m_start;
        write_byte(8'h90, 1'b0);
        write_byte(8'h00, 1'b0);
        m_start;
        write_byte(8'h91, 1'b0);
        read_byte(8'h5A, 1'b0, 8'h00);
        m_stop;

        // Data byte NACKed by user logic, then SCL activity ignored
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h00);
        push_evt(EV_RX, 8'h55); push_evt(EV_STOP, 8'h00);
        m_start;
        write_byte(8'h90, 1'b0);
        rx_ack_en = 1'b0;
        write_byte(8'h55, 1'b1);
        rx_ack_en = 1'b1;
        write_byte(8'hAA, 1'b1);
        m_stop;

        // Reset while the target drives a 0 data bit
        tx_byte = 8'h3C;
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h01); push_evt(EV_TXT, 8'h00);
        m_start;
        write_byte(8'h91, 1'b0);
        chk("tx_bit7_low", {15'b0, sda_val}, 16'h0000);
        nreset = 1'b0;
        #1;
        chk("rst_sda_release", {15'b0, sda_val}, 16'h0001);
        chk("rst_outs", {rx_byte, rx_valid, tx_taken, addr_match, read_nWrite,
                         start_det, stop_det, busy, 1'b0}, 16'h0000);
        #(3*Q);
        nreset = 1'b1;
        #(Q);

        // Next START after reset decodes normally
        push_evt(EV_START, 8'h00); push_evt(EV_ADDR, 8'h00);
        push_evt(EV_RX, 8'h66); push_evt(EV_STOP, 8'h00);
        m_start;
        write_byte(8'h90, 1'b0);
        write_byte(8'h66, 1'b0);
        m_stop;
        #(4*Q);

        chk("evt_queue_empty", 16'(exp_evt.size()), 16'h0000);
        chk("bus_queue_empty", 16'(exp_bus.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
